hazard_pattern_decoder: RTL and testbench
=========================================

# hazard_pattern_decoder

Receive-side monitor for the three-lamp hazard light bus. It samples the 3-bit lamp pattern stream driven by the hazard light generator and classifies consecutive pattern pairs. Once a mode has been seen for a configurable number of consecutive steps, it locks onto that mode (calm, 001→100 sweep, 100→001 sweep, or off). It flags any break in the sequence. It sits beside the generator on the lamp bus and feeds mode status to the system checker.

## Interface
- LOCK_COUNT, default 3: number of consecutive same-class transitions required to lock; legal range 1..15.
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- sample_en  input  1  when 1, `lights` is sampled on this clock edge; when 0, all state holds.
- lights  input  3  lamp pattern from the generator, with bit 2 as the left lamp and bit 0 as the right lamp.
- mode  output  2  detected mode, using the generator's select encoding:
  - 00: calm, 101↔010.
  - 01: sweep 001→010→100→001.
  - 10: sweep 100→010→001→100.
  - 11: off, 000→000.
- locked  output  1  1 while `mode` is valid.
- err  output  1  one-cycle pulse when a locked stream breaks.

## Operation
- Registers:
  - `prev`[2:0]: last sampled pattern.
  - `prev_valid`: set once a pattern has been sampled.
  - `run_class`[1:0]: class of the current run.
  - `run_cnt`: saturates at LOCK_COUNT; width is `$clog2(LOCK_COUNT+1)`.
  - `state` ∈ {UNLOCKED, LOCKED}.
  - `mode`, `err`: registered outputs.
- Transition class, computed from (`prev`, `lights`) when `prev_valid`=1. The pair sets are disjoint:
  - CALM (00): (101,010), (010,101).
  - UP (01): (001,010), (010,100), (100,001).
  - DOWN (10): (100,010), (010,001), (001,100).
  - OFF (11): (000,000).
  - Any other pair is INVALID.
- On a sampled edge, `prev` takes `lights` and `prev_valid` takes 1.
- The first sampled edge after reset only loads `prev`. No class is computed on that edge.
- UNLOCKED state:
  - Valid class equal to `run_class` with `run_cnt`>0: `run_cnt`++.
  - Valid class different from `run_class`, or `run_cnt`=0: `run_class` takes the new class and `run_cnt` takes 1.
  - INVALID: `run_cnt` takes 0.
  - When the updated `run_cnt` reaches LOCK_COUNT: go to LOCKED, `mode` takes `run_class`, `locked` takes 1.
- LOCKED state:
  - Class equal to `mode`: stay LOCKED; `run_cnt` stays saturated.
  - Any other class, including INVALID:
    - `err` pulses 1 for one cycle.
    - Go to UNLOCKED and clear `locked`.
    - `mode` holds its last value.
    - The new run starts as in UNLOCKED: `run_cnt` takes 1 with the new class if valid, else 0.
    - With LOCK_COUNT=1 and a valid new class, the block relocks on the same edge: `err` pulses, `locked` stays 1, and `mode` takes the new class.
- `sample_en`=0: no register changes, except that `err` returns to 0. Values on `lights` are ignored. Gaps in sampling do not break a run.
- Reset values: `locked`=0, `mode`=11, `err`=0, `state`=UNLOCKED, `run_cnt`=0, `run_class`=00, `prev`=000, `prev_valid`=0.

## Timing
- Classification is combinational from `prev` and `lights`. All outputs are registered, and none is combinationally dependent on inputs.
- Lock latency: `locked` rises after the (LOCK_COUNT+1)-th consecutive valid sampled edge from reset. Otherwise it rises after LOCK_COUNT matching transitions following a break.
- `err` is high for exactly the one cycle after the breaking edge. Back-to-back breaks cannot occur, because a break leaves the LOCKED state.
- Mode switches made by the generator produce at least one foreign or INVALID transition. Therefore a switch always produces `err` followed by relock after LOCK_COUNT new-class transitions.
- Reset asserted mid-run: all registers clear immediately and asynchronously. After release, the full lock latency applies again.

## Test plan
- Reset check: hold reset_n=0 while driving random `lights` with `sample_en`=1 → `locked`=0, `mode`=11, `err`=0 throughout.
- UP lock, LOCK_COUNT=3: drive 001, 010, 100, 001, one per cycle with `sample_en`=1 → `locked`=1 and `mode`=01 after the 4th edge, and `err` stays 0.
- Calm and off: drive 101, 010, 101, 010 → `mode`=00 locked. Then drive 000 ×5 → `err` pulses once, `mode` holds 00 while unlocked, then `locked`=1 with `mode`=11 after three 000→000 transitions.
- Break and relock: while locked in UP at `prev`=010, drive 011 → `err`=1 for one cycle and `locked`=0. Then drive 001, 010, 100, 001 → relocked 01 after the 4th edge.
- Direction change: while locked in UP, drive 100, 010, 001, 100 → `err` pulses on the first DOWN transition, then `locked`=1 with `mode`=10 after three DOWN transitions.
- Gaps and reset: after two UP transitions, hold `sample_en`=0 for 5 cycles with `lights`=111 → no state change, and the next UP transition locks. Separately, pulse reset_n low after two transitions → the block needs 4 fresh samples to lock.

Source files
------------

// File: rtl/hazard_pattern_decoder.sv
// Receive-side monitor for the three-lamp hazard bus: classifies consecutive
// lamp patterns, locks onto a repeating mode and flags breaks in a locked stream.
module hazard_pattern_decoder #(
   parameter int LOCK_COUNT = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       sample_en,
   input  logic [2:0] lights,
   output logic [1:0] mode,
   output logic       locked,
   output logic       err
);

   localparam int CNT_W = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(LOCK_COUNT);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

   typedef enum logic {UNLOCKED, LOCKED} state_t;

   state_t           state_q, state_d;
   logic [2:0]       prev_q, prev_d;
   logic             prev_valid_q, prev_valid_d;
   logic [1:0]       run_class_q, run_class_d;
   logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic [1:0]       mode_q, mode_d;
   logic             locked_q, locked_d;
   logic             err_q, err_d;

   logic             cls_valid;
   logic [1:0]       cls;
   logic [1:0]       run_class_n;
   logic [CNT_W-1:0] run_cnt_n;

   // Returns {valid, class}; the pair sets are disjoint so order does not matter.
   function automatic logic [2:0] classify(input logic [2:0] p, input logic [2:0] c);
      case ({p, c})
         6'b101_010, 6'b010_101:             classify = 3'b1_00;
         6'b001_010, 6'b010_100, 6'b100_001: classify = 3'b1_01;
         6'b100_010, 6'b010_001, 6'b001_100: classify = 3'b1_10;
         6'b000_000:                         classify = 3'b1_11;
         default:                            classify = 3'b0_00;
      endcase
   endfunction

   assign {cls_valid, cls} = classify(prev_q, lights);

   // Run update shared by both states; in LOCKED run_class equals mode, so a
   // foreign valid class naturally restarts the run at 1.
   always_comb begin
      run_class_n = run_class_q;
      run_cnt_n   = '0;
      if (cls_valid) begin
         if ((cls == run_class_q) && (run_cnt_q != '0)) begin
            run_cnt_n = (run_cnt_q == LOCK_CNT) ? LOCK_CNT : run_cnt_q + ONE_CNT;
         end else begin
            run_class_n = cls;
            run_cnt_n   = ONE_CNT;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      prev_d       = prev_q;
      prev_valid_d = prev_valid_q;
      run_class_d  = run_class_q;
      run_cnt_d    = run_cnt_q;
      mode_d       = mode_q;
      locked_d     = locked_q;
      err_d        = 1'b0;
      if (sample_en) begin
         prev_d       = lights;
         prev_valid_d = 1'b1;
         if (prev_valid_q && !((state_q == LOCKED) && cls_valid && (cls == mode_q))) begin
            if (state_q == LOCKED) begin
               err_d    = 1'b1;
               state_d  = UNLOCKED;
               locked_d = 1'b0;
            end
            run_class_d = run_class_n;
            run_cnt_d   = run_cnt_n;
            if (run_cnt_n == LOCK_CNT) begin
               state_d  = LOCKED;
               mode_d   = run_class_n;
               locked_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= UNLOCKED;
         prev_q       <= 3'b000;
         prev_valid_q <= 1'b0;
         run_class_q  <= 2'b00;
         run_cnt_q    <= '0;
         mode_q       <= 2'b11;
         locked_q     <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_q       <= prev_d;
         prev_valid_q <= prev_valid_d;
         run_class_q  <= run_class_d;
         run_cnt_q    <= run_cnt_d;
         mode_q       <= mode_d;
         locked_q     <= locked_d;
         err_q        <= err_d;
      end
   end

   assign mode   = mode_q;
   assign locked = locked_q;
   assign err    = err_q;

endmodule

// File: tb/tb_hazard_pattern_decoder.sv
// Directed bench for hazard_pattern_decoder: a vector table for LOCK_COUNT=3
// plus a hand sequence for a LOCK_COUNT=1 instance.
module tb_hazard_pattern_decoder;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       sample_en = 1'b0;
   logic [2:0] lights = 3'b000;
   logic [1:0] mode, mode1;
   logic       locked, locked1;
   logic       err, err1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rst_n;
      logic       en;
      logic [2:0] l;
      logic [1:0] m;
      logic       lk;
      logic       e;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   hazard_pattern_decoder #(.LOCK_COUNT(3)) dut (
      .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .lights(lights),
      .mode(mode), .locked(locked), .err(err)
   );

   hazard_pattern_decoder #(.LOCK_COUNT(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .lights(lights),
      .mode(mode1), .locked(locked1), .err(err1)
   );

   function automatic void add(input logic r, input logic en, input logic [2:0] l,
                               input logic [1:0] m, input logic lk, input logic e);
      vec_t v;
      v.rst_n = r; v.en = en; v.l = l; v.m = m; v.lk = lk; v.e = e;
      vecs.push_back(v);
   endfunction

   task automatic drive(input logic r, input logic en, input logic [2:0] l);
      @(negedge clk);
      reset_n   = r;
      sample_en = en;
      lights    = l;
      @(posedge clk);
      #1;
   endtask

   task automatic check1(input string name, input logic [1:0] m, input logic lk, input logic e);
      checks++;
      if ({mode1, locked1, err1} !== {m, lk, e}) begin
         errors++;
         $display("FAIL %s: got mode=%b locked=%b err=%b, want mode=%b locked=%b err=%b",
                  name, mode1, locked1, err1, m, lk, e);
      end
   endtask

   initial begin
      // reset held with random-looking lamps
      add(0,1,3'b111, 2'b11,0,0);
      add(0,1,3'b010, 2'b11,0,0);
      add(0,1,3'b101, 2'b11,0,0);
      // UP lock: first edge only loads prev
      add(1,1,3'b001, 2'b11,0,0);
      add(1,1,3'b010, 2'b11,0,0);
      add(1,1,3'b100, 2'b11,0,0);
      add(1,1,3'b001, 2'b01,1,0);
      add(1,1,3'b010, 2'b01,1,0);
      // break with 011, then relock
      add(1,1,3'b011, 2'b01,0,1);
      add(1,1,3'b001, 2'b01,0,0);
      add(1,1,3'b010, 2'b01,0,0);
      add(1,1,3'b100, 2'b01,0,0);
      add(1,1,3'b001, 2'b01,1,0);
      // direction change to DOWN
      add(1,1,3'b100, 2'b01,0,1);
      add(1,1,3'b010, 2'b01,0,0);
      add(1,1,3'b001, 2'b10,1,0);
      add(1,1,3'b100, 2'b10,1,0);
      // calm
      add(1,1,3'b101, 2'b10,0,1);
      add(1,1,3'b010, 2'b10,0,0);
      add(1,1,3'b101, 2'b10,0,0);
      add(1,1,3'b010, 2'b00,1,0);
      // off, mode holds 00 while unlocked
      add(1,1,3'b000, 2'b00,0,1);
      add(1,1,3'b000, 2'b00,0,0);
      add(1,1,3'b000, 2'b00,0,0);
      add(1,1,3'b000, 2'b11,1,0);
      add(1,1,3'b000, 2'b11,1,0);
      // two UP transitions, gap of 5 with 111, then lock on next UP
      add(1,1,3'b001, 2'b11,0,1);
      add(1,1,3'b010, 2'b11,0,0);
      add(1,1,3'b100, 2'b11,0,0);
      for (int i = 0; i < 5; i++) add(1,0,3'b111, 2'b11,0,0);
      add(1,1,3'b001, 2'b01,1,0);
      // break then a gap: err must drop during the gap
      add(1,1,3'b111, 2'b01,0,1);
      add(1,0,3'b010, 2'b01,0,0);
      add(1,1,3'b010, 2'b01,0,0);
      add(1,1,3'b100, 2'b01,0,0);
      add(1,1,3'b001, 2'b01,0,0);
      add(1,1,3'b010, 2'b01,1,0);
      // reset after two transitions: needs 4 fresh samples
      add(0,1,3'b100, 2'b11,0,0);
      add(1,1,3'b001, 2'b11,0,0);
      add(1,1,3'b010, 2'b11,0,0);
      add(1,1,3'b100, 2'b11,0,0);
      add(0,1,3'b001, 2'b11,0,0);
      add(1,1,3'b001, 2'b11,0,0);
      add(1,1,3'b010, 2'b11,0,0);
      add(1,1,3'b100, 2'b11,0,0);
      add(1,1,3'b001, 2'b01,1,0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst_n, vecs[i].en, vecs[i].l);
         checks++;
         if ({mode, locked, err} !== {vecs[i].m, vecs[i].lk, vecs[i].e}) begin
            errors++;
            $display("FAIL vec%0d: got mode=%b locked=%b err=%b, want mode=%b locked=%b err=%b",
                     i, mode, locked, err, vecs[i].m, vecs[i].lk, vecs[i].e);
         end
      end

      // LOCK_COUNT=1: lock on first transition, same-edge relock on direction change
      drive(0, 1, 3'b000);
      check1("lc1_reset", 2'b11, 0, 0);
      drive(1, 1, 3'b001);
      check1("lc1_load", 2'b11, 0, 0);
      drive(1, 1, 3'b010);
      check1("lc1_lock_up", 2'b01, 1, 0);
      drive(1, 1, 3'b001);
      check1("lc1_relock_down", 2'b10, 1, 1);
      drive(1, 1, 3'b100);
      check1("lc1_hold_down", 2'b10, 1, 0);
      drive(1, 1, 3'b101);
      check1("lc1_invalid_break", 2'b10, 0, 1);
      drive(1, 1, 3'b010);
      check1("lc1_lock_calm", 2'b00, 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
